// File: rtl/aqalu_vector_checker.sv
// Self-test engine for AQALU: accepts {A,B,op,expected} vectors, drives the ALU,
// compares its output after LAT_CYCLES and keeps pass/fail/skip counts plus elapsed seconds.
module aqalu_vector_checker #(
  parameter int unsigned LAT_CYCLES    = 1,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned TICKS_PER_SEC = 10_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [1:0]       vec_a,
  input  logic [1:0]       vec_b,
  input  logic [3:0]       vec_op,
  input  logic [7:0]       vec_exp,
  input  logic             vec_last,
  output logic [1:0]       alu_a,
  output logic [1:0]       alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_idx,
  output logic [3:0]       ff_op,
  output logic [7:0]       ff_exp,
  output logic [7:0]       ff_got,
  output logic [7:0]       seconds,
  output logic             done
);

  localparam int unsigned WAIT_W = $clog2(LAT_CYCLES + 1);
  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [7:0]         exp_q, exp_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   vidx_q, vidx_d, idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic               ffv_q, ffv_d;
  logic [CNT_W-1:0]   ffidx_q, ffidx_d;
  logic [3:0]         ffop_q, ffop_d;
  logic [7:0]         ffexp_q, ffexp_d, ffgot_q, ffgot_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [7:0]         sec_q, sec_d;
  logic               accept_c, resolve_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept_c  = (state_q == S_IDLE) && vec_valid;
  assign resolve_c = (state_q == S_WAIT) && (wait_q == WAIT_W'(LAT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_WAIT;
      S_WAIT:  if (resolve_c) state_d = last_q ? S_DONE : S_IDLE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_ready = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE:  vec_ready = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Vector capture, resolution and the free-running seconds timer.
  always_comb begin
    a_d = a_q;  b_d = b_q;  op_d = op_q;  exp_d = exp_q;  last_d = last_q;
    vidx_d = vidx_q;  idx_d = idx_q;  wait_d = wait_q;
    pass_d = pass_q;  fail_d = fail_q;  skip_d = skip_q;
    ffv_d = ffv_q;  ffidx_d = ffidx_q;  ffop_d = ffop_q;  ffexp_d = ffexp_q;  ffgot_d = ffgot_q;
    tick_d = tick_q + TICK_W'(1);
    sec_d  = sec_q;
    if (accept_c) begin
      a_d    = vec_a;
      b_d    = vec_b;
      op_d   = vec_op;
      exp_d  = vec_exp;
      last_d = vec_last;
      vidx_d = idx_q;
      idx_d  = idx_q + CNT_W'(1);
      wait_d = WAIT_W'(1);
    end else if ((state_q == S_WAIT) && !resolve_c) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    if (resolve_c) begin
      if (op_q >= 4'hE) begin
        skip_d = sat_inc(skip_q);
      end else if (alu_out == exp_q) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        if (!ffv_q) begin
          ffv_d   = 1'b1;
          ffidx_d = vidx_q;
          ffop_d  = op_q;
          ffexp_d = exp_q;
          ffgot_d = alu_out;
        end
      end
    end
    if (tick_q == TICK_W'(TICKS_PER_SEC - 1)) begin
      tick_d = '0;
      sec_d  = sec_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0;  b_q <= '0;  op_q <= '0;  exp_q <= '0;  last_q <= 1'b0;
      vidx_q <= '0;  idx_q <= '0;  wait_q <= '0;
      pass_q <= '0;  fail_q <= '0;  skip_q <= '0;
      ffv_q <= 1'b0;  ffidx_q <= '0;  ffop_q <= '0;  ffexp_q <= '0;  ffgot_q <= '0;
      tick_q <= '0;  sec_q <= '0;
    end else begin
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;  exp_q <= exp_d;  last_q <= last_d;
      vidx_q <= vidx_d;  idx_q <= idx_d;  wait_q <= wait_d;
      pass_q <= pass_d;  fail_q <= fail_d;  skip_q <= skip_d;
      ffv_q <= ffv_d;  ffidx_q <= ffidx_d;  ffop_q <= ffop_d;  ffexp_q <= ffexp_d;  ffgot_q <= ffgot_d;
      tick_q <= tick_d;  sec_q <= sec_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign skip_cnt   = skip_q;
  assign ff_valid   = ffv_q;
  assign ff_idx     = ffidx_q;
  assign ff_op      = ffop_q;
  assign ff_exp     = ffexp_q;
  assign ff_got     = ffgot_q;
  assign seconds    = sec_q;

endmodule

// File: tb/tb_aqalu_vector_checker.sv
// Scoreboard bench for aqalu_vector_checker: a driver queues the expected outcome of
// each accepted vector, a monitor checks it when the DUT's counters move.
module tb_aqalu_vector_checker;

  localparam int unsigned LAT = 3;
  localparam int unsigned CW  = 16;
  localparam int unsigned TPS = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          vec_valid, vec_ready, vec_last;
  logic [1:0]    vec_a, vec_b, alu_a, alu_b;
  logic [3:0]    vec_op, alu_opcode, ff_op;
  logic [7:0]    vec_exp, alu_out, ff_exp, ff_got, seconds;
  logic [CW-1:0] pass_cnt, fail_cnt, skip_cnt, ff_idx;
  logic          ff_valid, done;

  aqalu_vector_checker #(.LAT_CYCLES(LAT), .CNT_W(CW), .TICKS_PER_SEC(TPS)) dut (
    .clock(clock), .reset(reset), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_op(vec_op), .vec_exp(vec_exp), .vec_last(vec_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt),
    .ff_valid(ff_valid), .ff_idx(ff_idx), .ff_op(ff_op), .ff_exp(ff_exp), .ff_got(ff_got),
    .seconds(seconds), .done(done)
  );

  always #5 clock = ~clock;

  // Behavioural stand-in for the AQALU datapath.
  function automatic logic [7:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic [3:0] op);
    logic [7:0] xa, xb;
    xa = {6'b0, a};
    xb = {6'b0, b};
    case (op)
      4'd0:    return xa + xb;
      4'd1:    return xa - xb;
      4'd2:    return xa & xb;
      4'd3:    return xa | xb;
      4'd4:    return xa ^ xb;
      4'd5:    return xa * xb;
      4'd6:    return ~xa;
      4'd7:    return xa << b;
      default: return {op, a, b};
    endcase
  endfunction

  assign alu_out = alu_ref(alu_a, alu_b, alu_opcode);

  typedef struct {
    int         kind;   // 0 pass, 1 fail, 2 skip
    logic [CW-1:0] idx;
    logic [1:0] a, b;
    logic [3:0] op;
    logic [7:0] exp, got;
    logic       last;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rst_cyc = 0;
  int   prev_total = 0;
  logic [CW-1:0] m_idx;
  int   m_pass, m_fail, m_skip;
  logic m_ffv;
  logic [CW-1:0] m_ffidx;
  logic [3:0] m_ffop;
  logic [7:0] m_ffexp, m_ffgot;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    rst_cyc = cyc;
    sbq.delete();
    prev_total = 0;
    m_idx = '0;
    m_pass = 0; m_fail = 0; m_skip = 0;
    m_ffv = 1'b0; m_ffidx = '0; m_ffop = '0; m_ffexp = '0; m_ffgot = '0;
  endtask

  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op,
                      input logic [7:0] e, input logic last, input bit hold, output int acc);
    exp_t it;
    int   n;
    bit   got_it;
    vec_valid = 1'b1; vec_a = a; vec_b = b; vec_op = op; vec_exp = e; vec_last = last;
    n = 0; got_it = 1'b0; acc = -1;
    while (!got_it && n < 64) begin
      @(negedge clock);
      if (vec_ready) got_it = 1'b1;
      else n++;
    end
    if (!got_it) begin
      check("accept_timeout", 32'(n), 32'(0));
      vec_valid = 1'b0;
      return;
    end
    it.a = a; it.b = b; it.op = op; it.exp = e; it.last = last;
    it.got  = alu_ref(a, b, op);
    it.kind = (op >= 4'd14) ? 2 : ((it.got == e) ? 0 : 1);
    it.idx  = m_idx;
    m_idx   = m_idx + 1'b1;
    sbq.push_back(it);
    @(posedge clock);
    #1;
    acc = cyc;
    if (!hold) begin
      vec_valid = 1'b0;
      vec_a = 2'($urandom); vec_b = 2'($urandom); vec_op = 4'($urandom);
      vec_exp = 8'($urandom); vec_last = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    check("drain_queue_empty", 32'(sbq.size()), 32'(0));
  endtask

  // Monitor: a change in the resolved total means one vector was resolved this edge.
  int   mon_total;
  exp_t mon_it;
  always @(negedge clock) begin
    if (!reset) begin
      mon_total = int'(pass_cnt) + int'(fail_cnt) + int'(skip_cnt);
      if (mon_total != prev_total) begin
        if (sbq.size() == 0) begin
          check("unexpected_resolve", 32'(mon_total), 32'(prev_total));
        end else begin
          mon_it = sbq.pop_front();
          check("resolve_step", 32'(mon_total), 32'(prev_total + 1));
          case (mon_it.kind)
            0:       m_pass++;
            1:       m_fail++;
            default: m_skip++;
          endcase
          if (mon_it.kind == 1 && !m_ffv) begin
            m_ffv = 1'b1; m_ffidx = mon_it.idx; m_ffop = mon_it.op;
            m_ffexp = mon_it.exp; m_ffgot = mon_it.got;
          end
          check("pass_cnt", 32'(pass_cnt), 32'(m_pass));
          check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
          check("skip_cnt", 32'(skip_cnt), 32'(m_skip));
          check("ff_valid", 32'(ff_valid), 32'(m_ffv));
          check("ff_idx",   32'(ff_idx),   32'(m_ffidx));
          check("ff_op",    32'(ff_op),    32'(m_ffop));
          check("ff_exp",   32'(ff_exp),   32'(m_ffexp));
          check("ff_got",   32'(ff_got),   32'(m_ffgot));
          check("alu_a_held",  32'(alu_a), 32'(mon_it.a));
          check("alu_b_held",  32'(alu_b), 32'(mon_it.b));
          check("alu_op_held", 32'(alu_opcode), 32'(mon_it.op));
          check("done_after_resolve",  32'(done), 32'(mon_it.last));
          check("ready_after_resolve", 32'(vec_ready), 32'(!mon_it.last));
        end
        prev_total = mon_total;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_pass"},   32'(pass_cnt), 32'(0));
    check({tag, "_fail"},   32'(fail_cnt), 32'(0));
    check({tag, "_skip"},   32'(skip_cnt), 32'(0));
    check({tag, "_ready"},  32'(vec_ready), 32'(1));
    check({tag, "_done"},   32'(done), 32'(0));
    check({tag, "_ffv"},    32'(ff_valid), 32'(0));
    check({tag, "_alu_a"},  32'(alu_a), 32'(0));
    check({tag, "_alu_op"}, 32'(alu_opcode), 32'(0));
    check({tag, "_sec"},    32'(seconds), 32'(0));
  endtask

  initial begin
    int acc, prev_acc, n;
    logic [1:0] a, b;
    logic [3:0] op;
    logic [7:0] e;
    reset = 1'b1; vec_valid = 1'b0; vec_a = '0; vec_b = '0; vec_op = '0;
    vec_exp = '0; vec_last = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();
    check_reset_state("rst");

    // Single passing vector; ready stays low for exactly LAT cycles.
    send(2'd1, 2'd2, 4'd0, 8'd3, 1'b0, 1'b0, acc);
    n = 0;
    while (n < 20) begin
      @(negedge clock);
      if (vec_ready) break;
      n++;
    end
    check("ready_low_cycles", 32'(n), 32'(LAT));
    drain();
    check("t1_pass_cnt", 32'(pass_cnt), 32'(1));

    // idx1 ok, idx2 bad, idx3 ok, idx4 bad, idx5/6 skipped opcodes.
    for (int i = 1; i <= 6; i++) begin
      a = 2'($urandom); b = 2'($urandom); op = 4'($urandom_range(0, 13));
      e = alu_ref(a, b, op);
      if (i == 2 || i == 4) e = e ^ 8'h5A;
      if (i == 5) op = 4'd14;
      if (i == 6) op = 4'd15;
      send(a, b, op, e, 1'b0, 1'b0, acc);
    end
    drain();
    check("t2_fail_cnt", 32'(fail_cnt), 32'(2));
    check("t2_ff_idx",   32'(ff_idx),   32'(2));
    check("t3_skip_cnt", 32'(skip_cnt), 32'(2));
    check("t3_pass_cnt", 32'(pass_cnt), 32'(3));

    // Random vectors with random gaps.
    for (int i = 0; i < 24; i++) begin
      a = 2'($urandom); b = 2'($urandom); op = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom) : alu_ref(a, b, op);
      send(a, b, op, e, 1'b0, 1'b0, acc);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    drain();

    // Back-to-back stream with vec_valid held high, ending with vec_last.
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      a = 2'($urandom); b = 2'($urandom); op = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 2) == 0) ? 8'($urandom) : alu_ref(a, b, op);
      send(a, b, op, e, 1'(i == 7), 1'b1, acc);
      if (i > 0) check("stream_spacing", 32'(acc - prev_acc), 32'(LAT + 1));
      prev_acc = acc;
    end
    vec_last = 1'b0;
    repeat (12) @(negedge clock);
    check("t4_done", 32'(done), 32'(1));
    check("t4_ready_in_done", 32'(vec_ready), 32'(0));
    check("t4_queue_empty", 32'(sbq.size()), 32'(0));
    vec_valid = 1'b0;

    // Reset while a vector is in flight.
    do_reset();
    check_reset_state("rst2");
    send(2'd3, 2'd1, 4'd0, 8'd4, 1'b0, 1'b0, acc);
    check("t5_in_wait", 32'(vec_ready), 32'(0));
    do_reset();
    check("t5_pass", 32'(pass_cnt), 32'(0));
    check("t5_fail", 32'(fail_cnt), 32'(0));
    check("t5_skip", 32'(skip_cnt), 32'(0));
    check("t5_ready", 32'(vec_ready), 32'(1));
    repeat (LAT + 2) @(posedge clock);
    #1;
    check("t5_not_counted", 32'(pass_cnt) + 32'(fail_cnt) + 32'(skip_cnt), 32'(0));
    send(2'd2, 2'd2, 4'd2, 8'd2, 1'b1, 1'b0, acc);
    drain();
    check("t5_after_pass", 32'(pass_cnt), 32'(1));
    check("t5_after_done", 32'(done), 32'(1));

    // Seconds timer wrap with TICKS_PER_SEC=4.
    do_reset();
    repeat (1020) @(posedge clock);
    #1;
    check("sec_at_1020", 32'(seconds), 32'(255));
    repeat (4) @(posedge clock);
    #1;
    check("sec_at_1024", 32'(seconds), 32'(0));
    repeat (6) @(posedge clock);
    #1;
    check("sec_at_1030", 32'(seconds), 32'(((cyc - rst_cyc) / 4) % 256));
    check("sec_final", 32'(seconds), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
